spiflash_writer: RTL and testbench

- SPI NOR flash program/erase engine for the card's boot ROM flash. It is the write-side counterpart of the ROM read engine that fetches ROM contents.
- Accepts a single-byte program request from the host register interface. Issues WREN, then PAGE PROGRAM (0x02). Polls RDSR (0x05) until WIP clears, then reports done/error.
- Shares SPI_CLK/SPI_CS_n/SPI_MOSI/SPI_MISO with the read engine through a bus_req/bus_gnt handshake. The external pin mux selects this block only while bus_gnt=1.

---
 rtl/spiflash_pkg.sv | 26 ++
 rtl/spiflash_writer_shift.sv | 91 +++++++++
 rtl/spiflash_writer.sv | 178 +++++++++++++++++
 tb/tb_spiflash_writer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/spiflash_pkg.sv
// rtl/spiflash_pkg.sv - shared state encoding, opcodes and bit lengths for the SPI flash writer
package spiflash_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WAIT_GNT,
    ST_WREN,
    ST_GAP1,
    ST_CMD,
    ST_GAP2,
    ST_POLL,
    ST_GAP3,
    ST_DONE
  } state_t;

  localparam logic [7:0] CMD_WREN = 8'h06;
  localparam logic [7:0] CMD_PP   = 8'h02;
  localparam logic [7:0] CMD_RDSR = 8'h05;
  localparam logic [7:0] CMD_SE   = 8'h20;

  localparam logic [5:0] LEN_WREN = 6'd8;
  localparam logic [5:0] LEN_PP   = 6'd40;
  localparam logic [5:0] LEN_SE   = 6'd32;
  localparam logic [5:0] LEN_POLL = 6'd16;

endpackage

// File: rtl/spiflash_writer_shift.sv
// rtl/spiflash_writer_shift.sv - mode-0 bit shifter, 2 clk per bit, MSB first, falling-edge clocked
module spi_shift_engine (
  input  logic        clk,
  input  logic        IORST_n,
  input  logic        load,
  input  logic        abort,
  input  logic [39:0] tx_word,
  input  logic [5:0]  bit_cnt,
  input  logic        spi_miso,
  output logic        spi_clk,
  output logic        spi_mosi,
  output logic [7:0]  rx_byte,
  output logic        last
);

  logic [39:0] sh_q, sh_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [7:0]  rx_q, rx_d;
  logic        phase_q, phase_d;
  logic        active_q, active_d;
  logic        clk_q, clk_d;
  logic        mosi_q, mosi_d;

  always_ff @(negedge clk or negedge IORST_n) begin
    if (!IORST_n) begin
      sh_q     <= '0;
      cnt_q    <= '0;
      rx_q     <= '0;
      phase_q  <= 1'b0;
      active_q <= 1'b0;
      clk_q    <= 1'b0;
      mosi_q   <= 1'b0;
    end else begin
      sh_q     <= sh_d;
      cnt_q    <= cnt_d;
      rx_q     <= rx_d;
      phase_q  <= phase_d;
      active_q <= active_d;
      clk_q    <= clk_d;
      mosi_q   <= mosi_d;
    end
  end

  // phase_q=0 is the N half (CLK low, MOSI set up), phase_q=1 the P half (CLK high)
  always_comb begin
    sh_d     = sh_q;
    cnt_d    = cnt_q;
    rx_d     = rx_q;
    phase_d  = phase_q;
    active_d = active_q;
    clk_d    = clk_q;
    mosi_d   = mosi_q;
    if (abort) begin
      active_d = 1'b0;
      phase_d  = 1'b0;
      cnt_d    = '0;
      clk_d    = 1'b0;
      mosi_d   = 1'b0;
    end else if (load) begin
      sh_d     = {tx_word[38:0], 1'b0};
      mosi_d   = tx_word[39];
      clk_d    = 1'b0;
      phase_d  = 1'b0;
      cnt_d    = bit_cnt;
      active_d = 1'b1;
    end else if (active_q) begin
      if (!phase_q) begin
        clk_d   = 1'b1;
        phase_d = 1'b1;
      end else begin
        rx_d    = {rx_q[6:0], spi_miso};
        cnt_d   = cnt_q - 6'd1;
        phase_d = 1'b0;
        clk_d   = 1'b0;
        if (cnt_q == 6'd1) begin
          active_d = 1'b0;
          mosi_d   = 1'b0;
        end else begin
          mosi_d = sh_q[39];
          sh_d   = {sh_q[38:0], 1'b0};
        end
      end
    end
  end

  assign spi_clk  = clk_q;
  assign spi_mosi = mosi_q;
  assign rx_byte  = rx_q;
  assign last     = active_q && phase_q && (cnt_q == 6'd1);

endmodule

// File: rtl/spiflash_writer.sv
// rtl/spiflash_writer.sv - SPI NOR WREN/program/RDSR-poll engine sharing pins with the ROM reader
// SPIWR_ERASE_EN: when defined, erase=1 issues a 4 KiB sector erase instead of page program
module spiflash_writer
  import spiflash_pkg::*;
#(
  parameter int CS_GAP   = 4,
  parameter int POLL_MAX = 65535
) (
  input  logic        clk,
  input  logic        IORST_n,
  input  logic        start,
  input  logic        erase,
  input  logic [23:0] addr,
  input  logic [7:0]  wdata,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [7:0]  status,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic        SPI_CLK,
  output logic        SPI_CS_n,
  output logic        SPI_MOSI,
  input  logic        SPI_MISO
);

`ifdef SPIWR_ERASE_EN
  localparam logic ERASE_EN = 1'b1;
`else
  localparam logic ERASE_EN = 1'b0;
`endif
  localparam logic [7:0]  GAP_END  = 8'(CS_GAP - 1);
  localparam logic [15:0] POLL_LIM = 16'(POLL_MAX);

  state_t      state_q, state_d;
  logic [7:0]  gap_q, gap_d;
  logic [15:0] poll_q, poll_d;
  logic [23:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        erase_q, erase_d;
  logic        error_q, error_d;
  logic [7:0]  status_q, status_d;
  logic        cs_n_q, cs_n_d;

  logic        load, last, gnt_lost, gap_end;
  logic [39:0] tx_word;
  logic [5:0]  bit_cnt;
  logic [7:0]  rx_byte;

  assign gap_end  = (gap_q == GAP_END);
  assign gnt_lost = !bus_gnt && (state_q inside {ST_WREN, ST_GAP1, ST_CMD, ST_GAP2, ST_POLL, ST_GAP3});

  always_ff @(negedge clk or negedge IORST_n) begin
    if (!IORST_n) begin
      state_q  <= ST_IDLE;
      gap_q    <= '0;
      poll_q   <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      erase_q  <= 1'b0;
      error_q  <= 1'b0;
      status_q <= '0;
      cs_n_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      gap_q    <= gap_d;
      poll_q   <= poll_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      erase_q  <= erase_d;
      error_q  <= error_d;
      status_q <= status_d;
      cs_n_q   <= cs_n_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    gap_d    = gap_q;
    poll_d   = poll_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    erase_d  = erase_q;
    error_d  = error_q;
    status_d = status_q;
    cs_n_d   = cs_n_q;
    case (state_q)
      ST_IDLE: if (start) begin
        addr_d  = addr;
        wdata_d = wdata;
        erase_d = ERASE_EN & erase;
        error_d = 1'b0;
        poll_d  = '0;
        state_d = ST_WAIT_GNT;
      end
      ST_WAIT_GNT: if (bus_gnt) begin
        state_d = ST_WREN;
        cs_n_d  = 1'b0;
      end
      ST_WREN, ST_CMD, ST_POLL: if (last) begin
        state_d = (state_q == ST_WREN) ? ST_GAP1 : (state_q == ST_CMD) ? ST_GAP2 : ST_GAP3;
        cs_n_d  = 1'b1;
        gap_d   = '0;
      end
      ST_GAP1, ST_GAP2: begin
        gap_d = gap_q + 8'd1;
        if (gap_end) begin
          state_d = (state_q == ST_GAP1) ? ST_CMD : ST_POLL;
          poll_d  = (state_q == ST_GAP2) ? poll_q + 16'd1 : poll_q;
          cs_n_d  = 1'b0;
        end
      end
      ST_GAP3: begin
        // the shifter holds the last received byte while CS is high
        status_d = rx_byte;
        gap_d    = gap_q + 8'd1;
        if (gap_end) begin
          if (!rx_byte[0]) begin
            state_d = ST_DONE;
          end else if (poll_q == POLL_LIM) begin
            state_d = ST_DONE;
            error_d = 1'b1;
          end else begin
            state_d = ST_POLL;
            poll_d  = poll_q + 16'd1;
            cs_n_d  = 1'b0;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (gnt_lost) begin
      state_d = ST_DONE;
      cs_n_d  = 1'b1;
      error_d = 1'b1;
    end
  end

  always_comb begin
    load    = (state_d != state_q) && (state_d inside {ST_WREN, ST_CMD, ST_POLL});
    tx_word = {CMD_WREN, 32'h0};
    bit_cnt = LEN_WREN;
    case (state_d)
      ST_CMD: begin
        tx_word = erase_q ? {CMD_SE, addr_q, 8'h00} : {CMD_PP, addr_q, wdata_q};
        bit_cnt = erase_q ? LEN_SE : LEN_PP;
      end
      ST_POLL: begin
        tx_word = {CMD_RDSR, 32'h0};
        bit_cnt = LEN_POLL;
      end
      default: ;
    endcase
    busy    = (state_q != ST_IDLE) && (state_q != ST_DONE);
    bus_req = busy;
    done    = (state_q == ST_DONE);
  end

  spi_shift_engine u_shift (
    .clk      (clk),
    .IORST_n  (IORST_n),
    .load     (load),
    .abort    (gnt_lost),
    .tx_word  (tx_word),
    .bit_cnt  (bit_cnt),
    .spi_miso (SPI_MISO),
    .spi_clk  (SPI_CLK),
    .spi_mosi (SPI_MOSI),
    .rx_byte  (rx_byte),
    .last     (last)
  );

  assign SPI_CS_n = cs_n_q;
  assign error    = error_q;
  assign status   = status_q;

endmodule

// File: tb/tb_spiflash_writer.sv
// tb/tb_spiflash_writer.sv - directed bench for spiflash_writer with a small SPI flash model
module tb_spiflash_writer;

  logic        clk = 1'b0;
  logic        IORST_n = 1'b0;
  logic        start = 1'b0;
  logic        erase = 1'b0;
  logic [23:0] addr = '0;
  logic [7:0]  wdata = '0;
  logic        bus_gnt = 1'b1;
  logic        SPI_MISO = 1'b0;
  logic        busy, done, error, bus_req, SPI_CLK, SPI_CS_n, SPI_MOSI;
  logic [7:0]  status;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  spiflash_writer #(.CS_GAP(4), .POLL_MAX(4)) dut (
    .clk(clk), .IORST_n(IORST_n), .start(start), .erase(erase), .addr(addr),
    .wdata(wdata), .busy(busy), .done(done), .error(error), .status(status),
    .bus_req(bus_req), .bus_gnt(bus_gnt), .SPI_CLK(SPI_CLK), .SPI_CS_n(SPI_CS_n),
    .SPI_MOSI(SPI_MOSI), .SPI_MISO(SPI_MISO)
  );

  // flash model: records each CS-low transaction, answers RDSR from stat_seq
  int          bitn = 0;
  logic [39:0] sh = '0;
  logic [39:0] txd[$];
  int          txb[$];
  logic [7:0]  stat_seq[$];
  int          stat_idx = 0;
  int          rdsr_cnt = 0;
  logic [7:0]  cur_stat = '0;
  time         t_rise = 0;
  bit          have_rise = 0;
  int          min_gap = 1000;

  always @(negedge SPI_CS_n) begin
    bitn = 0;
    sh = '0;
    SPI_MISO = 1'b0;
    if (have_rise && int'(($time - t_rise) / 10) < min_gap) min_gap = int'(($time - t_rise) / 10);
  end

  always @(posedge SPI_CS_n) begin
    txd.push_back(sh);
    txb.push_back(bitn);
    t_rise = $time;
    have_rise = 1;
  end

  always @(posedge SPI_CLK) begin
    if (!SPI_CS_n) begin
      if (bitn < 40) sh[39 - bitn] = SPI_MOSI;
      bitn++;
    end
  end

  always @(negedge SPI_CLK) begin
    if (!SPI_CS_n) begin
      if (bitn == 8 && sh[39:32] == 8'h05) begin
        cur_stat = (stat_idx < stat_seq.size()) ? stat_seq[stat_idx] : stat_seq[$];
        stat_idx++;
        rdsr_cnt++;
      end
      if (bitn >= 8 && bitn < 16) SPI_MISO = cur_stat[15 - bitn];
      else SPI_MISO = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic clear_model();
    txd.delete();
    txb.delete();
    stat_seq.delete();
    stat_idx = 0;
    rdsr_cnt = 0;
    min_gap = 1000;
    have_rise = 0;
  endtask

  task automatic do_start(input logic [23:0] a, input logic [7:0] d, input logic e);
    @(posedge clk);
    addr = a;
    wdata = d;
    erase = e;
    start = 1'b1;
    @(posedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int pulses = 0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      if (done) pulses++;
      else if (pulses > 0) break;
    end
    check(tag, pulses, 1);
  endtask

  task automatic wait_bits(input int txn, input int nbits, output bit hit);
    hit = 0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      if (txd.size() == txn && bitn >= nbits) begin
        hit = 1;
        break;
      end
    end
  endtask

  initial begin
    bit hit;
    repeat (3) @(posedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_status", status, 8'h00);
    check("rst_bus_req", bus_req, 0);
    check("rst_clk", SPI_CLK, 0);
    check("rst_cs_n", SPI_CS_n, 1);
    check("rst_mosi", SPI_MOSI, 0);
    IORST_n = 1'b1;

    // program, flash ready on first poll
    clear_model();
    stat_seq.push_back(8'h00);
    do_start(24'h012345, 8'hA5, 1'b0);
    wait_done("p_done");
    check("p_ntxn", txd.size(), 3);
    check("p_wren", txd[0][39:32], 8'h06);
    check("p_wren_bits", txb[0], 8);
    check("p_cmd", txd[1], 40'h02012345A5);
    check("p_cmd_bits", txb[1], 40);
    check("p_rdsr", txd[2][39:32], 8'h05);
    check("p_rdsr_bits", txb[2], 16);
    check("p_gap_ge4", min_gap >= 4, 1);
    check("p_error", error, 0);
    check("p_status", status, 8'h00);
    check("p_busy", busy, 0);

    // busy flash: two busy polls then ready
    clear_model();
    stat_seq.push_back(8'h03);
    stat_seq.push_back(8'h03);
    stat_seq.push_back(8'h00);
    do_start(24'h000100, 8'h3C, 1'b0);
    wait_done("b_done");
    check("b_rdsr_cnt", rdsr_cnt, 3);
    check("b_error", error, 0);
    check("b_status", status, 8'h00);

    // stuck WIP: times out after POLL_MAX polls
    clear_model();
    stat_seq.push_back(8'h01);
    do_start(24'h000200, 8'h11, 1'b0);
    wait_done("t_done");
    check("t_rdsr_cnt", rdsr_cnt, 4);
    check("t_error", error, 1);
    check("t_status", status, 8'h01);

    // erase request; error from timeout clears on the new start
    clear_model();
    stat_seq.push_back(8'h00);
    do_start(24'h010000, 8'h77, 1'b1);
    wait_done("e_done");
    check("e_error", error, 0);
    check("e_wren", txd[0][39:32], 8'h06);
`ifdef SPIWR_ERASE_EN
    check("e_cmd_bits", txb[1], 32);
    check("e_cmd", txd[1][39:8], 32'h20010000);
`else
    check("e_cmd_bits", txb[1], 40);
    check("e_cmd", txd[1], 40'h0201000077);
`endif

    // grant loss mid-CMD, with a second start while waiting for the grant
    clear_model();
    stat_seq.push_back(8'h00);
    bus_gnt = 1'b0;
    do_start(24'h0ABCDE, 8'h11, 1'b0);
    do_start(24'h123456, 8'h22, 1'b0);
    check("g_busy", busy, 1);
    bus_gnt = 1'b1;
    wait_bits(1, 20, hit);
    check("g_reach", hit, 1);
    bus_gnt = 1'b0;
    @(posedge clk);
    check("g_cs_n", SPI_CS_n, 1);
    check("g_clk", SPI_CLK, 0);
    check("g_done", done, 1);
    check("g_error", error, 1);
    check("g_bus_req", bus_req, 0);
    check("g_bits", txb[1], 20);
    check("g_cmd_hi", txd[1][39:20], 20'h020AB);
    @(posedge clk);
    check("g_done_pulse", done, 0);
    bus_gnt = 1'b1;

    // async reset mid-CMD, then a fresh full sequence
    clear_model();
    stat_seq.push_back(8'h00);
    do_start(24'h00FF00, 8'h5A, 1'b0);
    wait_bits(1, 10, hit);
    check("r_reach", hit, 1);
    check("r_clk_hi", SPI_CLK, 1);
    #2;
    IORST_n = 1'b0;
    #1;
    check("r_cs_n", SPI_CS_n, 1);
    check("r_clk", SPI_CLK, 0);
    check("r_busy", busy, 0);
    check("r_bus_req", bus_req, 0);
    @(posedge clk);
    IORST_n = 1'b1;
    clear_model();
    stat_seq.push_back(8'h00);
    do_start(24'h00FF00, 8'h5A, 1'b0);
    wait_done("r2_done");
    check("r2_ntxn", txd.size(), 3);
    check("r2_wren", txd[0][39:32], 8'h06);
    check("r2_cmd", txd[1], 40'h0200FF005A);
    check("r2_error", error, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
